opsum_writeback: RTL and testbench

OPSUM_WRITEBACK -- requirements
Module: opsum_writeback

---
 rtl/tiling_pkg.sv | 11 +
 rtl/opsum_writeback_if.sv | 14 +
 rtl/opsum_writeback_wb_addr_gen.sv | 71 +++++++
 rtl/opsum_writeback.sv | 68 ++++++
 tb/tb_opsum_writeback.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/tiling_pkg.sv
// tiling_pkg: FSM state and tile dimension widths shared by the writeback and tiling loader.
package tiling_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int ROWS_W = 4;
  localparam int COLS_W = 8;
  localparam int CH_W = 6;
  localparam int OCOLS_W = 8;
  localparam int OCH_W = 10;
  localparam int RBASE_W = 8;
  localparam int CBASE_W = 10;
endpackage

// File: rtl/opsum_writeback_if.sv
// opsum_writeback_if: GLB read port and DRAM write port of the psum writeback engine.
interface opsum_writeback_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic [3:0] glb_re;
  logic [ADDR_WIDTH-1:0] glb_r_addr;
  logic [DATA_WIDTH*4-1:0] glb_r_data;
  logic dram_we;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic [DATA_WIDTH*4-1:0] dram_w_data;
  modport master(output glb_re, glb_r_addr, dram_we, dram_addr, dram_w_data, input glb_r_data);
  modport slave(input glb_re, glb_r_addr, dram_we, dram_addr, dram_w_data, output glb_r_data);
endinterface

// File: rtl/opsum_writeback_wb_addr_gen.sv
// wb_addr_gen: h/w/c tile counters with incremental GLB and DRAM byte-address accumulators.
module wb_addr_gen import tiling_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic [ADDR_WIDTH-1:0] glb_base,
  input  logic [ADDR_WIDTH-1:0] dram_base,
  input  logic [ROWS_W-1:0] rows,
  input  logic [COLS_W-1:0] cols,
  input  logic [CH_W-1:0] chs,
  input  logic [OCOLS_W-1:0] out_cols,
  input  logic [OCH_W-1:0] out_ch,
  input  logic [RBASE_W-1:0] row_base,
  input  logic [CBASE_W-1:0] ch_base,
  output logic [ADDR_WIDTH-1:0] glb_addr,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic last,
  output logic empty
);
  logic [ROWS_W-1:0] h, e;
  logic [COLS_W-1:0] w, f;
  logic [CH_W-1:0] c, pt;
  logic [ADDR_WIDTH-1:0] m4, stride, w_base, h_base, stride_in, origin;
  logic c_end, w_end, h_end;
  // Tile origin and row stride are formed once at start; per-element stepping is add-only.
  always_comb begin
    stride_in = ADDR_WIDTH'(out_cols) * ADDR_WIDTH'(out_ch) * ADDR_WIDTH'(4);
    origin = dram_base + ADDR_WIDTH'(row_base) * stride_in + (ADDR_WIDTH'(ch_base) << 2);
  end
  assign c_end = c == pt - 1'b1;
  assign w_end = w == f - 1'b1;
  assign h_end = h == e - 1'b1;
  assign last = c_end && w_end && h_end;
  assign empty = e == '0 || f == '0 || pt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      {h, w, c, e, f, pt} <= '0;
      {m4, stride, w_base, h_base, glb_addr, dram_addr} <= '0;
    end else if (load) begin
      {h, w, c} <= '0;
      e <= rows;
      f <= cols;
      pt <= chs;
      m4 <= ADDR_WIDTH'(out_ch) << 2;
      stride <= stride_in;
      glb_addr <= glb_base;
      dram_addr <= origin;
      w_base <= origin;
      h_base <= origin;
    end else if (step && !last) begin
      glb_addr <= glb_addr + ADDR_WIDTH'(4);
      c <= c_end ? '0 : c + 1'b1;
      if (!c_end) begin
        dram_addr <= dram_addr + ADDR_WIDTH'(4);
      end else if (!w_end) begin
        w <= w + 1'b1;
        w_base <= w_base + m4;
        dram_addr <= w_base + m4;
      end else begin
        w <= '0;
        h <= h + 1'b1;
        h_base <= h_base + stride;
        w_base <= h_base + stride;
        dram_addr <= h_base + stride;
      end
    end
  end
endmodule

// File: rtl/opsum_writeback.sv
// opsum_writeback: streams a psum tile from GLB into its place in the full DRAM output tensor.
module opsum_writeback import tiling_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] glb_opsum_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_opsum_base_addr,
  input  logic [ROWS_W-1:0] tile_rows,
  input  logic [COLS_W-1:0] tile_cols,
  input  logic [CH_W-1:0] tile_ch,
  input  logic [OCOLS_W-1:0] out_cols,
  input  logic [OCH_W-1:0] out_ch,
  input  logic [RBASE_W-1:0] row_base,
  input  logic [CBASE_W-1:0] ch_base,
  output logic busy,
  output logic finish,
  opsum_writeback_if.master bus
);
  state_t state, next;
  logic load, rd, last, empty, v1;
  logic [ADDR_WIDTH-1:0] glb_addr, gen_dram_addr, a1;
  logic [DATA_WIDTH*4-1:0] rd_data;
  assign load = state == IDLE && start;
  assign rd = state == RUN && !empty;
  assign busy = state != IDLE;
  assign finish = state == DONE;
  assign bus.glb_re = {4{rd}};
  assign bus.glb_r_addr = glb_addr;
  assign rd_data = bus.glb_r_data;
  wb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen (
    .clk(clk), .rst(rst), .load(load), .step(rd),
    .glb_base(glb_opsum_base_addr), .dram_base(dram_opsum_base_addr),
    .rows(tile_rows), .cols(tile_cols), .chs(tile_ch),
    .out_cols(out_cols), .out_ch(out_ch), .row_base(row_base), .ch_base(ch_base),
    .glb_addr(glb_addr), .dram_addr(gen_dram_addr), .last(last), .empty(empty)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? RUN : IDLE;
      RUN: next = empty ? DONE : (last ? DRAIN : RUN);
      DRAIN: next = v1 ? DRAIN : DONE;
      default: next = IDLE;
    endcase
  end
  // Address rides one stage behind the read so it meets the returning GLB data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      bus.dram_we <= 1'b0;
      bus.dram_addr <= '0;
      bus.dram_w_data <= '0;
    end else begin
      v1 <= rd;
      if (rd) a1 <= gen_dram_addr;
      bus.dram_we <= v1;
      if (v1) begin
        bus.dram_addr <= a1;
        bus.dram_w_data <= rd_data;
      end
    end
  end
endmodule

// File: tb/tb_opsum_writeback.sv
// tb_opsum_writeback: directed checks of tile writeback ordering, addressing, timing and reset abort.
module tb_opsum_writeback;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] glb_base = '0, dram_base = '0;
  logic [3:0] tile_rows = '0;
  logic [7:0] tile_cols = '0, out_cols = '0, row_base = '0;
  logic [5:0] tile_ch = '0;
  logic [9:0] out_ch = '0, ch_base = '0;
  logic busy, finish;
  opsum_writeback_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();
  opsum_writeback #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .glb_opsum_base_addr(glb_base), .dram_opsum_base_addr(dram_base),
    .tile_rows(tile_rows), .tile_cols(tile_cols), .tile_ch(tile_ch),
    .out_cols(out_cols), .out_ch(out_ch), .row_base(row_base), .ch_base(ch_base),
    .busy(busy), .finish(finish), .bus(bus)
  );
  always #5 clk = ~clk;
  localparam logic [31:0] D = 32'h0000_1000;
  logic [31:0] glb_mem [0:63];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.glb_re == 4'hF) bus.glb_r_data <= glb_mem[bus.glb_r_addr[7:2]];
  int nw = 0, fin_cnt = 0, fin_cyc = 0;
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  int log_cyc [0:63];
  always @(negedge clk) begin
    if (bus.dram_we) begin
      if (nw < 64) begin
        log_addr[nw] = bus.dram_addr;
        log_data[nw] = bus.dram_w_data;
        log_cyc[nw] = cyc;
      end
      nw++;
    end
    if (finish) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end
  int checks = 0, failures = 0;
  int s = 0, b = 0, f0 = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [31:0] gb, input logic [31:0] db, input logic [3:0] e,
                    input logic [7:0] fc, input logic [5:0] pt, input logic [7:0] fo,
                    input logic [9:0] m, input logic [7:0] rb, input logic [9:0] cb);
    @(posedge clk); #1;
    glb_base = gb; dram_base = db; tile_rows = e; tile_cols = fc; tile_ch = pt;
    out_cols = fo; out_ch = m; row_base = rb; ch_base = cb;
    start = 1'b1;
    s = cyc; b = nw; f0 = fin_cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_fin(input string tag);
    int k = 0;
    while (fin_cnt == f0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(fin_cnt - f0), 32'd1);
  endtask
  task automatic chk_tile(input string tag, input int idx [8]);
    chk({tag, "_count"}, 32'(nw - b), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_addr"}, log_addr[b + i], D + 32'(idx[i] * 4));
      chk({tag, "_data"}, log_data[b + i], 32'(i + 1));
    end
  endtask
  initial begin
    int exp1 [8] = '{0, 1, 8, 9, 32, 33, 40, 41};
    int exp2 [8] = '{68, 69, 76, 77, 100, 101, 108, 109};
    int k;
    for (int i = 0; i < 64; i++) glb_mem[i] = 32'(i + 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_glb_re", bus.glb_re, 0);
    chk("rst_dram_we", bus.dram_we, 0);
    chk("rst_glb_addr", bus.glb_r_addr, 0);
    chk("rst_dram_addr", bus.dram_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    // basic 2x2x2 tile into the top-left of a 4-wide, 8-channel output
    go(32'h0, D, 4'd2, 8'd2, 6'd2, 8'd4, 10'd8, 8'd0, 10'd0);
    wait_fin("t1_timeout");
    chk_tile("t1", exp1);
    chk("t1_first_lat", 32'(log_cyc[b] - s), 32'd3);
    chk("t1_last_lat", 32'(log_cyc[b + 7] - s), 32'd10);
    chk("t1_finish_lat", 32'(fin_cyc - s), 32'd11);
    @(negedge clk); #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_glb_re", bus.glb_re, 0);
    chk("t1_idle_dram_we", bus.dram_we, 0);
    chk("t1_hold_glb_addr", bus.glb_r_addr, 32'd28);
    chk("t1_hold_dram_addr", bus.dram_addr, D + 32'd164);
    // same tile placed at row 2, channel 4
    go(32'h0, D, 4'd2, 8'd2, 6'd2, 8'd4, 10'd8, 8'd2, 10'd4);
    wait_fin("t2_timeout");
    chk_tile("t2", exp2);
    // negative psum passes through bit-exact
    glb_mem[0] = 32'hFFFF_FF85;
    go(32'h0, D, 4'd1, 8'd1, 6'd1, 8'd4, 10'd8, 8'd1, 10'd3);
    wait_fin("t3_timeout");
    chk("t3_count", 32'(nw - b), 32'd1);
    chk("t3_addr", log_addr[b], D + 32'd140);
    chk("t3_data", log_data[b], 32'hFFFF_FF85);
    chk("t3_finish_lat", 32'(fin_cyc - s), 32'd4);
    glb_mem[0] = 32'd1;
    // zero channel count: no traffic, finish two cycles after start
    go(32'h0, D, 4'd2, 8'd2, 6'd0, 8'd4, 10'd8, 8'd0, 10'd0);
    @(negedge clk);
    chk("t4_busy", busy, 1);
    chk("t4_glb_re", bus.glb_re, 0);
    wait_fin("t4_timeout");
    chk("t4_finish_lat", 32'(fin_cyc - s), 32'd2);
    chk("t4_count", 32'(nw - b), 32'd0);
    // reset after the third write aborts the tile
    go(32'h0, D, 4'd2, 8'd2, 6'd2, 8'd4, 10'd8, 8'd0, 10'd0);
    k = 0;
    while (nw - b < 3 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t5_reach3", 32'(nw - b), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_finish", finish, 0);
    chk("t5_glb_re", bus.glb_re, 0);
    chk("t5_dram_we", bus.dram_we, 0);
    chk("t5_glb_addr", bus.glb_r_addr, 0);
    chk("t5_dram_addr", bus.dram_addr, 0);
    chk("t5_dram_data", bus.dram_w_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1 chk("t5_no_more_writes", 32'(nw - b), 32'd3);
    go(32'h0, D, 4'd2, 8'd2, 6'd2, 8'd4, 10'd8, 8'd0, 10'd0);
    wait_fin("t5b_timeout");
    chk_tile("t5b", exp1);
    // a second start while busy must not disturb the running tile
    go(32'h0, D, 4'd2, 8'd2, 6'd2, 8'd4, 10'd8, 8'd0, 10'd0);
    @(posedge clk); #1;
    glb_base = 32'h100; dram_base = 32'h8000; tile_rows = 4'd3; tile_ch = 6'd5; row_base = 8'd1; ch_base = 10'd2;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_fin("t6_timeout");
    chk_tile("t6", exp1);
    chk("t6_finish_lat", 32'(fin_cyc - s), 32'd11);
    repeat (4) @(negedge clk);
    chk("t6_single_finish", 32'(fin_cnt - f0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
